// File: rtl/apb_master.sv
// APB master: turns a single-command request/response handshake into an
// APB transfer on one of two slaves, with a bounded PREADY wait.
module apb_master #(
  parameter int DATA_SIZE = 7,
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 PCLK,
  input  logic                 PRESET_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [ADDR_SIZE:0]   cmd_addr_i,
  input  logic [DATA_SIZE:0]   cmd_wdata_i,
  output logic                 PSEL1_o,
  output logic                 PSEL2_o,
  output logic                 PENABLE_o,
  output logic                 PWRITE_o,
  output logic [ADDR_SIZE:0]   PADDR_o,
  output logic [DATA_SIZE:0]   PWDATA_o,
  input  logic [DATA_SIZE:0]   PRDATA1_i,
  input  logic [DATA_SIZE:0]   PRDATA2_i,
  input  logic                 PREADY1_i,
  input  logic                 PREADY2_i,
  output logic                 rsp_valid_o,
  output logic [DATA_SIZE:0]   rsp_rdata_o,
  output logic                 rsp_err_o
);

  // Wait counter only needs to hold 0 .. TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_reg, state_next;
  logic                 psel1_reg, psel1_next;
  logic                 psel2_reg, psel2_next;
  logic                 penable_reg, penable_next;
  logic                 pwrite_reg, pwrite_next;
  logic [ADDR_SIZE:0]   paddr_reg, paddr_next;
  logic [DATA_SIZE:0]   pwdata_reg, pwdata_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [DATA_SIZE:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                 rsp_err_reg, rsp_err_next;
  logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;

  // Only the slave addressed by the latched select bit is listened to.
  logic                 sel2;
  logic                 sel_ready;
  logic [DATA_SIZE:0]   sel_rdata;

  assign sel2      = paddr_reg[ADDR_SIZE];
  assign sel_ready = sel2 ? PREADY2_i : PREADY1_i;
  assign sel_rdata = sel2 ? PRDATA2_i : PRDATA1_i;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next     = state_reg;
    psel1_next     = psel1_reg;
    psel2_next     = psel2_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    wait_cnt_next  = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          state_next    = SETUP;
          pwrite_next   = cmd_write_i;
          paddr_next    = cmd_addr_i;
          pwdata_next   = cmd_wdata_i;
          psel1_next    = ~cmd_addr_i[ADDR_SIZE];
          psel2_next    = cmd_addr_i[ADDR_SIZE];
          wait_cnt_next = '0;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_next     = IDLE;
          psel1_next     = 1'b0;
          psel2_next     = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = pwrite_reg ? '0 : sel_rdata;
        end else if (wait_cnt_reg == CNT_LAST) begin
          // This is the TIMEOUT-th ACCESS cycle without PREADY: give up.
          state_next     = IDLE;
          psel1_next     = 1'b0;
          psel2_next     = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by PRESET_n.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_reg     <= IDLE;
      psel1_reg     <= 1'b0;
      psel2_reg     <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      psel1_reg     <= psel1_next;
      psel2_reg     <= psel2_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  assign cmd_ready_o = (state_reg == IDLE);
  assign PSEL1_o     = psel1_reg;
  assign PSEL2_o     = psel2_reg;
  assign PENABLE_o   = penable_reg;
  assign PWRITE_o    = pwrite_reg;
  assign PADDR_o     = paddr_reg;
  assign PWDATA_o    = pwdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of single transactions plus
// hand-written sequences for mid-transfer reset and back-to-back commands.
module tb_apb_master;

  logic       PCLK;
  logic       PRESET_n;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_write_i;
  logic [8:0] cmd_addr_i;
  logic [7:0] cmd_wdata_i;
  logic       PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o;
  logic [8:0] PADDR_o;
  logic [7:0] PWDATA_o;
  logic [7:0] PRDATA1_i, PRDATA2_i;
  logic       PREADY1_i, PREADY2_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o;

  apb_master #(.DATA_SIZE(7), .ADDR_SIZE(8), .TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .PSEL1_o(PSEL1_o), .PSEL2_o(PSEL2_o), .PENABLE_o(PENABLE_o),
    .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
    .PRDATA1_i(PRDATA1_i), .PRDATA2_i(PRDATA2_i),
    .PREADY1_i(PREADY1_i), .PREADY2_i(PREADY2_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    bit       write;
    bit [8:0] addr;
    bit [7:0] wdata;
    int       delay;      // ACCESS cycles with PREADY low before it rises
    bit       wrong;      // only the unselected slave raises PREADY
    bit [7:0] exp_rdata;
    bit       exp_err;
    int       exp_lat;    // cycles from accept edge to rsp_valid
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int acc_cnt;
  int errors;
  int checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave behaviour for one cycle, called on the falling edge.
  task automatic slave_drive(input logic sel2, input int delay, input bit wrong);
    logic rdy;
    rdy = 1'b0;
    if (PENABLE_o) begin
      rdy = (acc_cnt >= delay);
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
    if (wrong) rdy = 1'b0;
    PREADY1_i = wrong ? sel2 : (!sel2 && rdy);
    PREADY2_i = wrong ? !sel2 : (sel2 && rdy);
    PRDATA1_i = mem1[PADDR_o[7:0]];
    PRDATA2_i = mem2[PADDR_o[7:0]];
    if (rdy && PWRITE_o) begin
      if (sel2) mem2[PADDR_o[7:0]] = PWDATA_o;
      else      mem1[PADDR_o[7:0]] = PWDATA_o;
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    logic sel2;
    int lat, psel_cnt, pen_cnt;
    bit bad_sel;
    sel2 = v.addr[8];
    lat = 0; psel_cnt = 0; pen_cnt = 0; bad_sel = 0;
    @(negedge PCLK);
    chk("ready_idle", {31'b0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    @(posedge PCLK);
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      cmd_valid_i = 1'b0;
      if (rsp_valid_o) begin
        lat = k;
        chk("psel_off_rsp", {30'b0, PSEL1_o, PSEL2_o}, 32'd0);
        chk("penable_off_rsp", {31'b0, PENABLE_o}, 32'd0);
        slave_drive(sel2, v.delay, v.wrong);
        break;
      end
      if (sel2 ? PSEL2_o : PSEL1_o) psel_cnt++;
      if (PENABLE_o) pen_cnt++;
      if (sel2 ? PSEL1_o : PSEL2_o) bad_sel = 1'b1;
      if (k == 1) begin
        chk("setup_penable", {31'b0, PENABLE_o}, 32'd0);
        chk("setup_paddr", {23'b0, PADDR_o}, {23'b0, v.addr});
        chk("setup_pwrite", {31'b0, PWRITE_o}, {31'b0, v.write});
        chk("setup_pwdata", {24'b0, PWDATA_o}, {24'b0, v.wdata});
      end
      slave_drive(sel2, v.delay, v.wrong);
    end
    chk("latency", lat, v.exp_lat);
    chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, v.exp_err});
    chk("rsp_rdata", {24'b0, rsp_rdata_o}, {24'b0, v.exp_rdata});
    chk("psel_cycles", psel_cnt, v.exp_lat - 1);
    chk("penable_cycles", pen_cnt, v.exp_lat - 2);
    chk("other_psel", {31'b0, bad_sel}, 32'd0);
    $display("txn %0d: write=%0d addr=0x%03h lat=%0d err=%0d rdata=0x%02h",
             idx, v.write, v.addr, lat, rsp_err_o, rsp_rdata_o);
    @(negedge PCLK);
    slave_drive(sel2, v.delay, v.wrong);
    chk("rsp_pulse_end", {31'b0, rsp_valid_o}, 32'd0);
    chk("rsp_rdata_hold", {24'b0, rsp_rdata_o}, {24'b0, v.exp_rdata});
    chk("rsp_err_hold", {31'b0, rsp_err_o}, {31'b0, v.exp_err});
    chk("paddr_hold", {23'b0, PADDR_o}, {23'b0, v.addr});
  endtask

  initial begin
    int k;
    errors = 0; checks = 0; acc_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'(i + 16);
      mem2[i] = 8'(i) ^ 8'hC3;
    end
    //              wr    addr     wdata  dly wrong rdata  err lat
    vecs[0]  = '{1'b1, 9'h0A5, 8'h3C, 1,  1'b0, 8'h00, 1'b0, 4};
    vecs[1]  = '{1'b1, 9'h1A5, 8'h77, 0,  1'b0, 8'h00, 1'b0, 3};
    vecs[2]  = '{1'b0, 9'h1A5, 8'h11, 1,  1'b0, 8'h77, 1'b0, 4};
    vecs[3]  = '{1'b0, 9'h0A5, 8'h22, 0,  1'b0, 8'h3C, 1'b0, 3};
    vecs[4]  = '{1'b0, 9'h012, 8'h33, 2,  1'b0, 8'h22, 1'b0, 5};
    vecs[5]  = '{1'b0, 9'h112, 8'h44, 0,  1'b0, 8'hD1, 1'b0, 3};
    vecs[6]  = '{1'b0, 9'h040, 8'h55, 99, 1'b0, 8'h00, 1'b1, 17};
    vecs[7]  = '{1'b1, 9'h1FF, 8'hE1, 0,  1'b1, 8'h00, 1'b1, 17};
    vecs[8]  = '{1'b0, 9'h1FF, 8'h66, 0,  1'b0, 8'h3C, 1'b0, 3};
    vecs[9]  = '{1'b0, 9'h0FF, 8'h88, 14, 1'b0, 8'h0F, 1'b0, 17};
    vecs[10] = '{1'b0, 9'h0FF, 8'h99, 13, 1'b0, 8'h0F, 1'b0, 16};

    PRESET_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    PRDATA1_i = '0; PRDATA2_i = '0; PREADY1_i = 1'b0; PREADY2_i = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("reset_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("reset_outs", {PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o, rsp_valid_o, rsp_err_o, 26'b0}, 32'd0);
    chk("reset_buses", {PADDR_o, PWDATA_o, rsp_rdata_o, 7'b0}, 32'd0);
    PRESET_n = 1'b1;

    for (int i = 0; i < NVEC; i++) do_txn(vecs[i], i);

    // Reset asserted in the middle of ACCESS, away from any clock edge.
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 9'h120; cmd_wdata_i = 8'hB7;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid_i = 1'b0;
    slave_drive(1'b1, 99, 1'b0);
    @(negedge PCLK);
    slave_drive(1'b1, 99, 1'b0);
    chk("mid_access", {30'b0, PSEL2_o, PENABLE_o}, 32'd3);
    #2 PRESET_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("async_rst_outs", {PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o, rsp_valid_o, rsp_err_o, 26'b0}, 32'd0);
    chk("async_rst_buses", {PADDR_o, PWDATA_o, rsp_rdata_o, 7'b0}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      chk("rst_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    PRESET_n = 1'b1;
    $display("txn reset: PRESET_n pulsed during ACCESS of write 0x120");
    do_txn('{1'b0, 9'h0A5, 8'h00, 0, 1'b0, 8'h3C, 1'b0, 3}, 100);

    // Two commands queued with cmd_valid held high throughout.
    @(negedge PCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 9'h003; cmd_wdata_i = 8'h5A;
    @(posedge PCLK);
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge PCLK);
      slave_drive(1'b0, 0, 1'b0);
      chk("b2b_no_overlap", {30'b0, PSEL1_o, PSEL2_o} & 32'd1 & {31'b0, PSEL1_o & PSEL2_o}, 32'd0);
      if (rsp_valid_o) begin k = c; break; end
    end
    chk("b2b_first_lat", k, 3);
    chk("b2b_ready_in_rsp", {31'b0, cmd_ready_o}, 32'd1);
    cmd_write_i = 1'b0; cmd_addr_i = 9'h103; cmd_wdata_i = 8'h00;
    @(negedge PCLK);
    cmd_valid_i = 1'b0;
    chk("b2b_setup_sel", {29'b0, PSEL1_o, PSEL2_o, PENABLE_o}, 32'd2);
    chk("b2b_setup_addr", {23'b0, PADDR_o}, 32'h103);
    slave_drive(1'b1, 0, 1'b0);
    k = 0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge PCLK);
      slave_drive(1'b1, 0, 1'b0);
      chk("b2b_no_psel1", {31'b0, PSEL1_o}, 32'd0);
      if (rsp_valid_o) begin k = c; break; end
    end
    chk("b2b_second_lat", k, 3);
    chk("b2b_rdata", {24'b0, rsp_rdata_o}, 32'hC0);
    chk("b2b_write_landed", {24'b0, mem1[3]}, 32'h5A);
    $display("txn b2b: write 0x003 then read 0x103 rdata=0x%02h", rsp_rdata_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
